// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle RV32I control path: FSM states, opcodes and
// the datapath select codes that the ALU control decoder also understands.
package rv_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMREAD,
        MEMWB,
        MEMWRITE,
        EXEC_R,
        EXEC_I,
        ALUWB,
        BEQ,
        JAL,
        TRAP
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Raw control word decoded from the state, before reset gating and branch resolution.
    typedef struct packed {
        logic       pc_update;
        logic       branch;
        logic       adr_src;
        logic       mem_req;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       instr_done;
    } ctrl_t;

    function automatic logic is_mem_state(input state_t s);
        return (s == FETCH) || (s == MEMREAD) || (s == MEMWRITE);
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control/status bundle between the multicycle control FSM (master) and the datapath
// plus memory port (slave).
interface multicycle_control_if;
    import rv_ctrl_pkg::*;

    logic [6:0] opcode;
    logic       zero;
    logic       mem_ready;

    logic       pc_write;
    logic       adr_src;
    logic       mem_req;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       instr_done;
    logic       mem_timeout;
    logic       illegal_instr;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_write, adr_src, mem_req, mem_write, ir_write, reg_write,
               result_src, alu_src_a, alu_src_b, alu_op, instr_done,
               mem_timeout, illegal_instr
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_write, adr_src, mem_req, mem_write, ir_write, reg_write,
               result_src, alu_src_a, alu_src_b, alu_op, instr_done,
               mem_timeout, illegal_instr
    );

endinterface

// File: rtl/multicycle_control_mem_wait_timer.sv
// Counts stalled cycles of a memory access and flags the cycle in which the
// access has waited MAX_WAIT cycles and memory is still not ready.
module mem_wait_timer #(
    parameter int MAX_WAIT = 15,
    parameter int WAIT_W   = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic active,
    input  logic ready,
    input  logic clear,
    output logic timeout
);
    import rv_ctrl_pkg::*;

    logic [WAIT_W-1:0] wait_cnt;

    // A ready memory always wins over an expiring count.
    assign timeout = active && !ready && (wait_cnt == WAIT_W'(MAX_WAIT));

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (clear) begin
            wait_cnt <= '0;
        end else if (active && !ready) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle RV32I core. Optional build macro ILLEGAL_TRAP_EN
// turns unknown opcodes into a sticky trap instead of a NOP.
module multicycle_control #(
    parameter int MAX_WAIT = 15,
    parameter int WAIT_W   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master bus
);
    import rv_ctrl_pkg::*;

    state_t state;
    state_t state_next;
    ctrl_t  ctrl;
    ctrl_t  ctrl_out;
    logic   timeout;
    logic   timeout_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        ctrl       = '0;
        state_next = state;
        case (state)
            FETCH: begin
                ctrl.mem_req    = 1'b1;
                ctrl.alu_src_a  = SRCA_PC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.alu_op     = ALU_ADD;
                ctrl.result_src = RES_ALU;
                // On timeout the state simply stays in FETCH so the same PC is retried.
                if (bus.mem_ready) begin
                    ctrl.ir_write  = 1'b1;
                    ctrl.pc_update = 1'b1;
                    state_next     = DECODE;
                end
            end
            DECODE: begin
                ctrl.alu_src_a = SRCA_OLDPC;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
                case (bus.opcode)
                    OP_LW, OP_SW: state_next = MEMADR;
                    OP_R:         state_next = EXEC_R;
                    OP_I:         state_next = EXEC_I;
                    OP_BEQ:       state_next = BEQ;
                    OP_JAL:       state_next = JAL;
                    default: begin
`ifdef ILLEGAL_TRAP_EN
                        state_next = TRAP;
`else
                        ctrl.instr_done = 1'b1;
                        state_next      = FETCH;
`endif
                    end
                endcase
            end
            MEMADR: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
                state_next     = (bus.opcode == OP_SW) ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                ctrl.mem_req = 1'b1;
                ctrl.adr_src = 1'b1;
                if (bus.mem_ready) begin
                    state_next = MEMWB;
                end else if (timeout) begin
                    state_next = FETCH;
                end
            end
            MEMWB: begin
                ctrl.result_src = RES_DATA;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
                state_next      = FETCH;
            end
            MEMWRITE: begin
                ctrl.mem_req   = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.adr_src   = 1'b1;
                if (bus.mem_ready) begin
                    ctrl.instr_done = 1'b1;
                    state_next      = FETCH;
                end else if (timeout) begin
                    state_next = FETCH;
                end
            end
            EXEC_R: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_RS2;
                ctrl.alu_op    = ALU_FUNCT;
                state_next     = ALUWB;
            end
            EXEC_I: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_FUNCT;
                state_next     = ALUWB;
            end
            ALUWB: begin
                ctrl.result_src = RES_ALUOUT;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
                state_next      = FETCH;
            end
            BEQ: begin
                ctrl.alu_src_a  = SRCA_RS1;
                ctrl.alu_src_b  = SRCB_RS2;
                ctrl.alu_op     = ALU_SUB;
                ctrl.result_src = RES_ALUOUT;
                ctrl.branch     = 1'b1;
                ctrl.instr_done = 1'b1;
                state_next      = FETCH;
            end
            JAL: begin
                ctrl.alu_src_a  = SRCA_OLDPC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.alu_op     = ALU_ADD;
                ctrl.result_src = RES_ALUOUT;
                ctrl.pc_update  = 1'b1;
                state_next      = ALUWB;
            end
            TRAP: begin
`ifdef ILLEGAL_TRAP_EN
                state_next = TRAP;
`else
                state_next = FETCH;
`endif
            end
            default: state_next = FETCH;
        endcase
    end

    mem_wait_timer #(
        .MAX_WAIT (MAX_WAIT),
        .WAIT_W   (WAIT_W)
    ) u_mem_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .active  (is_mem_state(state)),
        .ready   (bus.mem_ready),
        .clear   ((state_next != state) || timeout),
        .timeout (timeout)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            timeout_q <= 1'b0;
        end else if (timeout) begin
            timeout_q <= 1'b1;
        end
    end

    // Reset kills every enable and select in the same cycle, so an interrupted instruction writes nothing.
    assign ctrl_out = reset ? '0 : ctrl;

    assign bus.pc_write    = ctrl_out.pc_update | (ctrl_out.branch & bus.zero);
    assign bus.adr_src     = ctrl_out.adr_src;
    assign bus.mem_req     = ctrl_out.mem_req;
    assign bus.mem_write   = ctrl_out.mem_write;
    assign bus.ir_write    = ctrl_out.ir_write;
    assign bus.reg_write   = ctrl_out.reg_write;
    assign bus.result_src  = ctrl_out.result_src;
    assign bus.alu_src_a   = ctrl_out.alu_src_a;
    assign bus.alu_src_b   = ctrl_out.alu_src_b;
    assign bus.alu_op      = ctrl_out.alu_op;
    assign bus.instr_done  = ctrl_out.instr_done;
    assign bus.mem_timeout = timeout_q;

`ifdef ILLEGAL_TRAP_EN
    logic illegal_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            illegal_q <= 1'b0;
        end else if (state == DECODE && state_next == TRAP) begin
            illegal_q <= 1'b1;
        end
    end

    assign bus.illegal_instr = illegal_q;
`else
    assign bus.illegal_instr = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: each instruction is expanded into its expected
// per-cycle control words from the instruction-level timing rules, then replayed against the DUT.
module tb_multicycle_control;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    multicycle_control_if bus();

    multicycle_control #(
        .MAX_WAIT (15),
        .WAIT_W   (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int compared   = 0;
    int mismatched = 0;

    typedef struct packed {
        logic [14:0] w;
        logic        rdy;
    } cyc_t;

    cyc_t plan[$];

    logic [14:0] obsWord;
    assign obsWord = {bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.result_src,
                      bus.adr_src, bus.mem_req, bus.mem_write, bus.ir_write,
                      bus.reg_write, bus.pc_write, bus.instr_done};

    function automatic logic [14:0] word(input logic [1:0] a, input logic [1:0] b,
                                         input logic [1:0] op, input logic [1:0] rs,
                                         input logic adr, input logic req, input logic mwr,
                                         input logic irw, input logic regw, input logic pcw,
                                         input logic done);
        return {a, b, op, rs, adr, req, mwr, irw, regw, pcw, done};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [14:0] w, input logic rdy);
        cyc_t c;
        c.w   = w;
        c.rdy = rdy;
        plan.push_back(c);
    endtask

    // A memory access stalls for 'waits' cycles, then completes.
    task automatic memStep(input logic [14:0] wWait, input logic [14:0] wDone, input int waits);
        for (int i = 0; i < waits; i++) push(wWait, 1'b0);
        push(wDone, 1'b1);
    endtask

    task automatic buildInstr(input logic [6:0] op, input logic z, input int wf, input int wm);
        logic [14:0] dec;
        logic [14:0] aluwb;
        plan.delete();
        dec   = word(2'd1, 2'd1, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0);
        aluwb = word(2'd0, 2'd0, 2'd0, 2'd0, 0, 0, 0, 0, 1, 0, 1);
        memStep(word(2'd0, 2'd2, 2'd0, 2'd2, 0, 1, 0, 0, 0, 0, 0),
                word(2'd0, 2'd2, 2'd0, 2'd2, 0, 1, 0, 1, 0, 1, 0), wf);
        case (op)
            7'b0000011: begin
                push(dec, 1'($urandom));
                push(word(2'd2, 2'd1, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0), 1'($urandom));
                memStep(word(2'd0, 2'd0, 2'd0, 2'd0, 1, 1, 0, 0, 0, 0, 0),
                        word(2'd0, 2'd0, 2'd0, 2'd0, 1, 1, 0, 0, 0, 0, 0), wm);
                push(word(2'd0, 2'd0, 2'd0, 2'd1, 0, 0, 0, 0, 1, 0, 1), 1'($urandom));
            end
            7'b0100011: begin
                push(dec, 1'($urandom));
                push(word(2'd2, 2'd1, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0), 1'($urandom));
                memStep(word(2'd0, 2'd0, 2'd0, 2'd0, 1, 1, 1, 0, 0, 0, 0),
                        word(2'd0, 2'd0, 2'd0, 2'd0, 1, 1, 1, 0, 0, 0, 1), wm);
            end
            7'b0110011: begin
                push(dec, 1'($urandom));
                push(word(2'd2, 2'd0, 2'd2, 2'd0, 0, 0, 0, 0, 0, 0, 0), 1'($urandom));
                push(aluwb, 1'($urandom));
            end
            7'b0010011: begin
                push(dec, 1'($urandom));
                push(word(2'd2, 2'd1, 2'd2, 2'd0, 0, 0, 0, 0, 0, 0, 0), 1'($urandom));
                push(aluwb, 1'($urandom));
            end
            7'b1100011: begin
                push(dec, 1'($urandom));
                push(word(2'd2, 2'd0, 2'd1, 2'd0, 0, 0, 0, 0, 0, z, 1), 1'($urandom));
            end
            7'b1101111: begin
                push(dec, 1'($urandom));
                push(word(2'd1, 2'd2, 2'd0, 2'd0, 0, 0, 0, 0, 0, 1, 0), 1'($urandom));
                push(aluwb, 1'($urandom));
            end
            default: begin
`ifdef ILLEGAL_TRAP_EN
                push(dec, 1'($urandom));
                for (int i = 0; i < 3; i++) push(15'd0, 1'($urandom));
`else
                push(word(2'd1, 2'd1, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 1), 1'($urandom));
`endif
            end
        endcase
    endtask

    // Replays the first n planned cycles (all of them when n < 0); called #1 after a rising edge.
    task automatic applyStimulus(input string tag, input int n);
        int last;
        last = (n < 0 || n > plan.size()) ? plan.size() : n;
        for (int i = 0; i < last; i++) begin
            bus.mem_ready = plan[i].rdy;
            @(negedge clk);
            checkOutput($sformatf("%s_c%0d", tag, i + 1), 32'(obsWord), 32'(plan[i].w));
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [6:0] randomOpcode();
        logic [6:0] ops[8];
        ops[0] = 7'b0000011;
        ops[1] = 7'b0100011;
        ops[2] = 7'b0110011;
        ops[3] = 7'b0010011;
        ops[4] = 7'b1100011;
        ops[5] = 7'b1101111;
        ops[6] = 7'b1111111;
        ops[7] = 7'b0010111;
`ifdef ILLEGAL_TRAP_EN
        return ops[$urandom_range(0, 5)];
`else
        return ops[$urandom_range(0, 7)];
`endif
    endfunction

    initial begin
        logic [6:0] op;
        logic       z;
        int         wf;
        int         wm;

        reset         = 1'b1;
        bus.opcode    = 7'b0000011;
        bus.zero      = 1'b1;
        bus.mem_ready = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput("reset_outputs", 32'(obsWord), 32'd0);
            checkOutput("reset_timeout", 32'(bus.mem_timeout), 32'd0);
            checkOutput("reset_illegal", 32'(bus.illegal_instr), 32'd0);
            @(posedge clk);
            #1;
        end
        reset = 1'b0;

        for (int k = 0; k < 120; k++) begin
            op = randomOpcode();
            z  = 1'($urandom);
            wf = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            wm = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            bus.opcode = op;
            bus.zero   = z;
            buildInstr(op, z, wf, wm);
            applyStimulus($sformatf("rand%0d_op%b", k, op), -1);
        end
        checkOutput("rand_no_timeout", 32'(bus.mem_timeout), 32'd0);

        bus.opcode = 7'b1100011;
        for (int k = 0; k < 2; k++) begin
            bus.zero = 1'(k);
            buildInstr(7'b1100011, 1'(k), 0, 0);
            applyStimulus($sformatf("beq_zero%0d", k), -1);
        end

        bus.opcode = 7'b0100011;
        buildInstr(7'b0100011, 1'b0, 0, 3);
        applyStimulus("sw_wait3", -1);

        bus.opcode = 7'b0000011;
        buildInstr(7'b0000011, 1'b0, 15, 15);
        applyStimulus("lw_ready_at_limit", -1);
        checkOutput("ready_at_limit_no_timeout", 32'(bus.mem_timeout), 32'd0);

`ifndef ILLEGAL_TRAP_EN
        bus.opcode = 7'b1111111;
        buildInstr(7'b1111111, 1'b0, 0, 0);
        applyStimulus("unknown_nop", -1);
        checkOutput("nop_illegal_tied0", 32'(bus.illegal_instr), 32'd0);
`endif

        // Fetch stalled forever: waits 0..15 stay in FETCH, the 16th stalled cycle times out.
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            checkOutput($sformatf("tmo_fetch_w%0d", i), 32'(obsWord),
                        32'(word(2'd0, 2'd2, 2'd0, 2'd2, 0, 1, 0, 0, 0, 0, 0)));
            checkOutput($sformatf("tmo_flag_w%0d", i), 32'(bus.mem_timeout), 32'd0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        checkOutput("tmo_flag_set", 32'(bus.mem_timeout), 32'd1);
        @(posedge clk);
        #1;
        bus.opcode = 7'b0110011;
        buildInstr(7'b0110011, 1'b0, 0, 0);
        applyStimulus("after_tmo_add", -1);
        checkOutput("tmo_sticky", 32'(bus.mem_timeout), 32'd1);

        // Reset in the MEMREAD cycle of a lw.
        bus.opcode = 7'b0000011;
        buildInstr(7'b0000011, 1'b0, 0, 2);
        applyStimulus("lw_pre_reset", 3);
        reset         = 1'b1;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        checkOutput("reset_in_memread", 32'(obsWord), 32'd0);
        @(posedge clk);
        #1;
        reset         = 1'b0;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        checkOutput("fetch_after_reset", 32'(obsWord),
                    32'(word(2'd0, 2'd2, 2'd0, 2'd2, 0, 1, 0, 0, 0, 0, 0)));
        checkOutput("reset_clears_timeout", 32'(bus.mem_timeout), 32'd0);
        @(posedge clk);
        #1;
        bus.opcode = 7'b1101111;
        buildInstr(7'b1101111, 1'b0, 1, 0);
        applyStimulus("jal_after_reset", -1);

`ifdef ILLEGAL_TRAP_EN
        bus.opcode = 7'b1111111;
        buildInstr(7'b1111111, 1'b0, 0, 0);
        applyStimulus("trap", -1);
        checkOutput("trap_illegal_set", 32'(bus.illegal_instr), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("trap_reset_clears", 32'(bus.illegal_instr), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
